// File: rtl/psum_acc.sv
// psum_acc: accumulates PE psum beats across input-channel passes into ping-pong tile banks and drains finished tiles.
// Define ACC_SAT_EN to saturate lane adds instead of wrapping.
module psum_acc #(
  parameter int TILE_LEN = 16,
  parameter int LANES    = 8,
  parameter int PSUM_W   = 16,
  parameter int ACC_W    = 24,
  parameter int LEN_W    = $clog2(TILE_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES*PSUM_W-1:0] in_data,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    in_eop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic [1:0]              err
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LANES*ACC_W-1:0] bank_q [2][TILE_LEN];
  logic [LEN_W-1:0] len_q [2];
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0] pend_q, pend_d, err_q, err_d;
  logic [LANES*ACC_W-1:0] cur, wdata;
  logic acc, done, rel, wrap;

  function automatic logic [ACC_W-1:0] add_lane(input logic [ACC_W-1:0] a, input logic [PSUM_W-1:0] p, input logic first);
`ifdef ACC_SAT_EN
    logic [ACC_W:0] s;
    s = (first ? '0 : {a[ACC_W-1], a}) + {{(ACC_W+1-PSUM_W){p[PSUM_W-1]}}, p};
    return (s[ACC_W] != s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
`else
    return (first ? '0 : a) + {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
`endif
  endfunction

  assign acc       = in_valid && !pend_q[wr_bank_q];
  assign done      = acc && in_eop && in_last;
  assign wrap      = wr_ptr_q == LEN_W'(TILE_LEN-1);
  assign cur       = bank_q[wr_bank_q][wr_ptr_q];
  assign out_valid = state_q == DRAIN;
  assign out_data  = out_valid ? bank_q[rd_bank_q][rd_ptr_q] : '0;
  assign out_last  = out_valid && rd_ptr_q == len_q[rd_bank_q];
  assign rel       = out_valid && out_ready && out_last;
  assign busy      = |pend_q || out_valid;
  assign err       = err_q;

  always_comb begin
    wdata = '0;
    for (int l = 0; l < LANES; l++)
      wdata[l*ACC_W +: ACC_W] = add_lane(cur[l*ACC_W +: ACC_W], in_data[l*PSUM_W +: PSUM_W], in_first);
  end

  always_comb begin
    wr_bank_d = wr_bank_q ^ done;
    wr_ptr_d  = acc ? ((in_eop || wrap) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    err_d     = err_q | {acc && !in_eop && wrap, in_valid && !acc};
    pend_d    = pend_q;
    if (done) pend_d[wr_bank_q] = 1'b1;
    if (rel) pend_d[rd_bank_q] = 1'b0;
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    if (state_q == IDLE) begin
      if (pend_q[rd_bank_q]) begin
        state_d  = DRAIN;
        rd_ptr_d = '0;
      end
    end else if (out_ready) begin
      state_d   = out_last ? IDLE : DRAIN;
      rd_bank_d = rd_bank_q ^ out_last;
      rd_ptr_d  = out_last ? rd_ptr_q : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  // storage and tile lengths are not reset; pending flags gate every read
  always_ff @(posedge clk) begin
    if (acc) bank_q[wr_bank_q][wr_ptr_q] <= wdata;
    if (done) len_q[wr_bank_q] <= wr_ptr_q;
  end
endmodule

// File: doc/psum_acc.md
Name: psum_acc

Overview:
- Sits directly downstream of the PE array and its controller.
- Each PE result beat (one tile column, LANES row psums) is accumulated across input-channel passes into a ping-pong tile buffer.
- When the last input-channel pass of an output channel completes, the finished bank is drained to the output writer over a valid/ready stream. Accumulation continues into the other bank meanwhile.

Parameters:
- TILE_LEN, 16, max tile columns per pass (bank depth).
- LANES, 8, psum lanes per beat (PE rows).
- PSUM_W, 16, signed width of one incoming psum lane.
- ACC_W, 24, signed width of one accumulator lane (ACC_W > PSUM_W).
- LEN_W, $clog2(TILE_LEN), column pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  psum beat valid (driven from the PE pvalid).
- in_data  in  LANES*PSUM_W  signed psums, lane 0 in the LSBs.
- in_first  in  1  beat belongs to the first input-channel pass.
- in_last  in  1  beat belongs to the last input-channel pass.
- in_eop  in  1  last beat (column) of the current pass.
- out_valid  out  1  drained accumulator entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  LANES*ACC_W  accumulated column, lane 0 in the LSBs.
- out_last  out  1  final column of the tile.
- busy  out  1  any bank pending or draining.
- err  out  2  sticky errors: [0] bank overrun (beat dropped), [1] column overflow.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. There is no backpressure on the input side.
- Reset values:
  - out_valid=0, out_last=0, out_data=0, busy=0, err=0.
  - wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, both pending flags=0, FSM=IDLE.
  - Bank storage is not reset.
- Sign extension: every lane is sign-extended PSUM_W to ACC_W. Addition wraps modulo 2^ACC_W (unless ACC_SAT_EN).
- Accepted beat: in_valid=1 and pending[wr_bank]=0. For an accepted beat, in the same cycle:
  - bank[wr_bank][wr_ptr] <= in_first ? sext(in_data) : bank[wr_bank][wr_ptr] + sext(in_data), per lane.
  - The read is combinational from the flop array; the write takes effect on the next edge (1-cycle RMW, no hazard since wr_ptr advances).
  - in_first=in_last=1 in the same beat is legal (single-pass channel).
- Pointer update on an accepted beat:
  - in_eop=1: wr_ptr<=0.
  - wr_ptr==TILE_LEN-1 with in_eop=0: wr_ptr<=0 and err[1]<=1 (wrap).
  - Otherwise: wr_ptr<=wr_ptr+1.
- Tile completion: an accepted beat with in_eop=1 and in_last=1 does all of the following:
  - pending[wr_bank]<=1.
  - len[wr_bank]<=wr_ptr (stored as last index).
  - wr_bank toggles.
- Dropped beat: in_valid=1 while pending[wr_bank]=1. The beat is not written, the pointer does not move, and err[0]<=1.
- Drain FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when pending[rd_bank]=1; rd_ptr<=0.
  - In DRAIN:
    - out_valid=1.
    - out_data=bank[rd_bank][rd_ptr].
    - out_last=(rd_ptr==len[rd_bank]).
    - out_data holds stable until accepted.
  - On out_valid&out_ready with out_last=0: rd_ptr++.
  - On out_valid&out_ready with out_last=1: pending[rd_bank]<=0, rd_bank toggles, and the FSM returns to IDLE. There is always a one-cycle bubble between tiles.
  - out_valid is never withdrawn without a handshake.
- Latency: if the completing eop beat is in cycle t, then pending is set after t, DRAIN is entered after t+1, and the first out_valid=1 is in cycle t+2 (when the FSM was IDLE).
- Simultaneous events:
  - Bank completion and drain release in the same cycle are both applied.
  - A beat written to wr_bank while the other bank drains is legal.
  - A release of bank X in the same cycle as a beat arriving for bank X: the beat is dropped, because the pending check uses the registered value.
- busy = pending[0] | pending[1] | (state==DRAIN).
- err bits clear only on rst.
- Reset mid-operation: all progress is lost; out_valid falls on the next edge.

Optional Feature:
- Macro: ACC_SAT_EN.
- When defined, each lane add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
- When undefined, the add wraps modulo 2^ACC_W.
- Interface and latency are identical either way.

Test Plan:
- Single pass, 16 beats, lane data = column index, in_first=in_last=1 -> out_data lanes 0..15 in order, out_last on the 16th handshake, first out_valid 2 cycles after the eop beat.
- 3 passes, 4 columns, every lane = 5 each pass, out_ready=1 -> 4 outputs, each lane = 15, out_last on the 4th.
- Lane values -1 then +3 (PSUM_W=16) -> lane = 2 (sign extension correct).
- Two tiles back to back with out_ready=0 throughout, then a third tile's first beat -> both pending, third beat dropped, err=2'b01. Release out_ready -> tile A then tile B, with a 1-cycle bubble between.
- 17 beats without eop -> err[1]=1, 17th beat written to column 0.
- Accumulate 2^(ACC_W-1)-1 plus 1 -> 2^(ACC_W-1)-1 with ACC_SAT_EN, -2^(ACC_W-1) without. Then assert rst mid-drain -> next cycle out_valid=0, busy=0, err=0.
